// File: rtl/ssp_slave_frontend.sv
// SSP slave front end: synchronizes the 4-wire SSP pins into the Clk domain
// and turns each 16-bit frame into register-port controls for the UART core.
module ssp_slave_frontend #(
    parameter int   SYNC_STAGES = 2,
    parameter logic MISO_IDLE   = 1'b0
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        SSEL_n,
    input  logic        SCK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] SSP_DO,
    output logic        SSP_SSEL,
    output logic [2:0]  SSP_RA,
    output logic        SSP_WnR,
    output logic        SSP_En,
    output logic        SSP_EOC,
    output logic [11:0] SSP_DI,
    output logic        Abort
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] ssel_q;
    logic [SYNC_STAGES-1:0] sck_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic ssel_s;
    logic sck_s;
    logic mosi_s;

    logic sck_d;
    logic mosi_d;
    logic rise_sck;
    logic fall_sck;

    state_t      state, state_n;
    logic [3:0]  bit_cnt, bit_cnt_n;
    logic [15:0] shift, shift_n;
    logic [2:0]  ra_n;
    logic        wnr_n;
    logic [11:0] di_n;
    logic        en_n;
    logic        eoc_n;
    logic        abort_n;
    logic [15:0] shift_in;

    logic [11:0] tx;
    logic        tx_loaded;

    assign ssel_s = ssel_q[SYNC_STAGES-1];
    assign sck_s  = sck_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // Pin synchronizers, reset to the idle pin levels.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ssel_q <= '1;
            sck_q  <= '0;
            mosi_q <= '0;
        end else begin
            ssel_q <= {ssel_q[SYNC_STAGES-2:0], SSEL_n};
            sck_q  <= {sck_q[SYNC_STAGES-2:0], SCK};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
        end
    end

    // Registered SCK edge strobes; MOSI delayed to stay aligned with them.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            sck_d    <= 1'b0;
            mosi_d   <= 1'b0;
            rise_sck <= 1'b0;
            fall_sck <= 1'b0;
        end else begin
            sck_d    <= sck_s;
            mosi_d   <= mosi_s;
            rise_sck <= sck_s & ~sck_d;
            fall_sck <= ~sck_s & sck_d;
        end
    end

    assign shift_in = {shift[14:0], mosi_d};

    // Frame FSM state and decoded register-port outputs.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            shift   <= 16'd0;
            SSP_RA  <= 3'd0;
            SSP_WnR <= 1'b0;
            SSP_DI  <= 12'd0;
            SSP_En  <= 1'b0;
            SSP_EOC <= 1'b0;
            Abort   <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            SSP_RA  <= ra_n;
            SSP_WnR <= wnr_n;
            SSP_DI  <= di_n;
            SSP_En  <= en_n;
            SSP_EOC <= eoc_n;
            Abort   <= abort_n;
        end
    end

    // Next-state logic; deselect is checked before the SCK strobe so it wins.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        ra_n      = SSP_RA;
        wnr_n     = SSP_WnR;
        di_n      = SSP_DI;
        en_n      = 1'b0;
        eoc_n     = 1'b0;
        abort_n   = 1'b0;
        case (state)
            IDLE: begin
                bit_cnt_n = 4'd0;
                if (!ssel_s) begin
                    state_n = HDR;
                end
            end
            HDR: begin
                if (ssel_s) begin
                    state_n   = IDLE;
                    bit_cnt_n = 4'd0;
                    abort_n   = (bit_cnt != 4'd0);
                end else if (rise_sck) begin
                    shift_n   = shift_in;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd3) begin
                        ra_n    = shift_in[3:1];
                        wnr_n   = shift_in[0];
                        en_n    = 1'b1;
                        state_n = DATA;
                    end
                end
            end
            DATA: begin
                if (ssel_s) begin
                    state_n   = IDLE;
                    bit_cnt_n = 4'd0;
                    abort_n   = 1'b1;
                end else if (rise_sck) begin
                    shift_n   = shift_in;
                    bit_cnt_n = bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        di_n    = shift_in[11:0];
                        eoc_n   = 1'b1;
                        state_n = HDR;
                    end
                end
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = 4'd0;
            end
        endcase
    end

    // Read-data shifter: first fall in DATA loads SSP_DO, later falls shift.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            tx        <= 12'd0;
            tx_loaded <= 1'b0;
        end else if (state != DATA) begin
            tx_loaded <= 1'b0;
        end else if (fall_sck) begin
            if (!tx_loaded) begin
                tx        <= SSP_DO;
                tx_loaded <= 1'b1;
            end else begin
                tx <= {tx[10:0], 1'b0};
            end
        end
    end

    assign MISO = (state == DATA && tx_loaded && !SSP_WnR) ? tx[11] : MISO_IDLE;

    assign SSP_SSEL = ~ssel_s;

endmodule
